hazard_scoreboard_unit: RTL and testbench
=========================================

HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 Parameter NUM_REGS, default 32, number of architectural registers; REG_AW = clog2(NUM_REGS).
REQ-002 Parameter LOAD_LAT, default 2, cycles (1..7) from load issue until the result is forwardable.
REQ-003 Parameter MC_CW, default 6, width of multi-cycle operation length input.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 id_valid  input  1  ID stage holds a valid instruction.
REQ-007 id_rs1_addr, id_rs2_addr  input  REG_AW  ID source registers.
REQ-008 id_rs1_used, id_rs2_used  input  1  source actually read by the instruction.
REQ-009 id_mem_read  input  1  ID instruction is a load.
REQ-010 id_rd_addr  input  REG_AW  ID destination register.
REQ-011 ex_mc_start  input  1  EX begins a multi-cycle operation (mul/div) this cycle.
REQ-012 ex_mc_cycles  input  MC_CW  extra cycles the multi-cycle operation occupies EX.
REQ-013 branch_taken  input  1  EX resolved a taken branch/jump this cycle.
REQ-014 stall_if, stall_id  output  1  hold PC and IF/ID register.
REQ-015 bubble_ex  output  1  insert NOP into ID/EX.
REQ-016 flush_if, flush_id, flush_ex  output  1  squash the named stage.
REQ-017 mc_busy  output  1  multi-cycle operation in progress.

Function
REQ-018 Scoreboard: one down-counter of width clog2(LOAD_LAT+1) per register; nonzero = result pending.
REQ-019 A load is issued when id_valid & id_mem_read & !stall_id & !branch_taken & id_rd_addr!=0; next cycle, counter[id_rd_addr] = LOAD_LAT.
REQ-020 Every nonzero counter not being reloaded decrements by 1 each cycle; a reload takes priority over the decrement for the same register.
REQ-021 Load-use hazard = id_valid & ((id_rs1_used & rs1!=0 & counter[rs1]!=0) | (id_rs2_used & rs2!=0 & counter[rs2]!=0)); combinational on current state.
REQ-022 Register 0 never causes a hazard and is never marked pending.
REQ-023 Multi-cycle FSM states IDLE, BUSY: IDLE->BUSY on ex_mc_start with ex_mc_cycles!=0, loading mc_cnt=ex_mc_cycles; BUSY decrements each cycle; BUSY->IDLE when mc_cnt reaches 1 (i.e. after exactly ex_mc_cycles cycles in BUSY); ex_mc_cycles==0 stays IDLE.
REQ-024 mc_busy = (state==BUSY), registered.
REQ-025 stall_if = stall_id = !branch_taken & (load-use hazard | mc_busy).
REQ-026 bubble_ex = !branch_taken & load-use hazard & !mc_busy; while mc_busy, ID/EX is held, not bubbled.
REQ-027 flush_if = flush_id = flush_ex = branch_taken, for exactly the cycle branch_taken is high.
REQ-028 Branch priority: branch_taken overrides all stalls in that cycle; a branch with ex_mc_start in the same cycle does not enter BUSY.
REQ-029 branch_taken while BUSY is ignored (EX held); the FSM continues.
REQ-030 Pending scoreboard entries are unaffected by flushes (older loads still complete).
REQ-031 All outputs are valid in the same cycle as their inputs (zero-latency decode); state updates on the next edge.

Reset
REQ-032 On rising clk with rst_n=0: all scoreboard counters 0, FSM IDLE, mc_cnt 0; the cycle after, all outputs 0 given idle inputs.
REQ-033 Reset asserted mid-operation aborts BUSY and clears all pending entries in that same edge; no deferred stall survives.

Configuration
REQ-034 Macro HAZARD_PERF_CNT_EN: when defined, add outputs perf_stall_cnt[31:0] (cycles with stall_id=1) and perf_flush_cnt[31:0] (cycles with branch_taken=1), both saturating at 0xFFFFFFFF and cleared by reset; when undefined, these ports and all associated logic are absent and the remaining behaviour is identical.

Verification
REQ-035 Load x5 issued, next ID instruction reads rs1=x5 -> stall_if=stall_id=bubble_ex=1 for LOAD_LAT-1... specifically for 2 cycles with LOAD_LAT=2 (counter 2,1), then 0 with counter reaching 0.
REQ-036 Load to x0 followed by a read of x0 -> no stall in any cycle.
REQ-037 ex_mc_start with ex_mc_cycles=4 -> mc_busy=1 and stall_id=1 for exactly 4 cycles, bubble_ex=0 throughout.
REQ-038 Load-use hazard and branch_taken in the same cycle -> flush_if/id/ex=1, stall_id=0, no scoreboard entry for the flushed ID load.
REQ-039 rst_n=0 for one edge during BUSY with 3 cycles remaining and x7 pending -> next cycle mc_busy=0, read of x7 causes no stall.
REQ-040 With HAZARD_PERF_CNT_EN: 5 stall cycles and 2 branches -> perf_stall_cnt=5, perf_flush_cnt=2; preloaded to 0xFFFFFFFF via forced state -> remains 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// Pipeline hazard control: per-register load scoreboard (load-use stalls),
// multi-cycle EX occupancy FSM (mul/div), and taken-branch flush control.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall/flush
// performance counters; leaving it undefined removes those ports and logic.
module hazard_scoreboard_unit #(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 2,
  parameter int MC_CW    = 6,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_mem_read,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              ex_mc_start,
  input  logic [MC_CW-1:0]  ex_mc_cycles,
  input  logic              branch_taken,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_if,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              mc_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_LAT);

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  logic [CNT_W-1:0] sb_q [NUM_REGS];
  logic [CNT_W-1:0] sb_d [NUM_REGS];
  logic             state_q, state_d;
  logic [MC_CW-1:0] mc_cnt_q, mc_cnt_d;

  logic rs1_pend, rs2_pend, load_use, load_issue;

  // Load-use detection and stall/flush decode on the current scoreboard state.
  always_comb begin
    rs1_pend   = id_rs1_used && (id_rs1_addr != '0) && (sb_q[id_rs1_addr] != '0);
    rs2_pend   = id_rs2_used && (id_rs2_addr != '0) && (sb_q[id_rs2_addr] != '0);
    load_use   = id_valid && (rs1_pend || rs2_pend);
    mc_busy    = (state_q == BUSY);
    stall_id   = !branch_taken && (load_use || mc_busy);
    stall_if   = stall_id;
    // While EX is occupied by a multi-cycle op, ID/EX holds rather than bubbles.
    bubble_ex  = !branch_taken && load_use && !mc_busy;
    flush_if   = branch_taken;
    flush_id   = branch_taken;
    flush_ex   = branch_taken;
    load_issue = id_valid && id_mem_read && !stall_id && !branch_taken &&
                 (id_rd_addr != '0);
  end

  // Scoreboard next state: a fresh load reload wins over the countdown; x0 stays clear.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      sb_d[r] = sb_q[r];
      if (sb_q[r] != '0) sb_d[r] = sb_q[r] - CNT_W'(1);
      if (load_issue && (id_rd_addr == REG_AW'(r))) sb_d[r] = LOAD_VAL;
    end
    sb_d[0] = '0;
  end

  // Scoreboard counters; reset discards every pending load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) sb_q[r] <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // Multi-cycle FSM next state: a same-cycle taken branch cancels the start,
  // and branches seen while BUSY do not disturb the countdown.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    case (state_q)
      IDLE: begin
        if (ex_mc_start && !branch_taken && (ex_mc_cycles != '0)) begin
          state_d  = BUSY;
          mc_cnt_d = ex_mc_cycles;
        end
      end
      BUSY: begin
        if (mc_cnt_q == MC_CW'(1)) begin
          state_d  = IDLE;
          mc_cnt_d = '0;
        end else begin
          mc_cnt_d = mc_cnt_q - MC_CW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        mc_cnt_d = '0;
      end
    endcase
  end

  // Multi-cycle FSM registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Saturating event counters for stall and flush cycles.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_id && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_d = perf_stall_q + 32'd1;
    if (branch_taken && (perf_flush_q != 32'hFFFF_FFFF)) perf_flush_d = perf_flush_q + 32'd1;
  end

  // Performance counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Testbench for hazard_scoreboard_unit: directed hazard scenarios with literal
// expectations, plus a per-cycle comparison against a cycle-count based model.
module tb_hazard_scoreboard_unit;
  localparam int NUM_REGS = 32;
  localparam int LOAD_LAT = 2;
  localparam int MC_CW    = 6;
  localparam int REG_AW   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic              id_rs1_used, id_rs2_used, id_mem_read;
  logic              ex_mc_start;
  logic [MC_CW-1:0]  ex_mc_cycles;
  logic              branch_taken;
  logic              stall_if, stall_id, bubble_ex, flush_if, flush_id, flush_ex, mc_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]       perf_stall_cnt, perf_flush_cnt;
`endif

  hazard_scoreboard_unit #(.NUM_REGS(NUM_REGS), .LOAD_LAT(LOAD_LAT), .MC_CW(MC_CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_mem_read(id_mem_read), .id_rd_addr(id_rd_addr),
    .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles),
    .branch_taken(branch_taken),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
    .mc_busy(mc_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: absolute cycle numbers at which each register becomes ready and
  // at which EX becomes free.
  int cyc = 0;
  int ready_at [NUM_REGS];
  int busy_until = 0;
  int m_pstall = 0;
  int m_pflush = 0;

  logic s_stall_if, s_stall_id, s_bubble, s_flush_if, s_flush_id, s_flush_ex, s_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit haz, busy, e_stall, e_bubble;
    @(negedge clk);
    haz = id_valid &&
          ((id_rs1_used && id_rs1_addr != 0 && cyc < ready_at[id_rs1_addr]) ||
           (id_rs2_used && id_rs2_addr != 0 && cyc < ready_at[id_rs2_addr]));
    busy     = cyc < busy_until;
    e_stall  = !branch_taken && (haz || busy);
    e_bubble = !branch_taken && haz && !busy;
    if (rst_n) begin
      chk("stall_if", {31'd0, stall_if}, {31'd0, e_stall});
      chk("stall_id", {31'd0, stall_id}, {31'd0, e_stall});
      chk("bubble_ex", {31'd0, bubble_ex}, {31'd0, e_bubble});
      chk("flush_if", {31'd0, flush_if}, {31'd0, branch_taken});
      chk("flush_id", {31'd0, flush_id}, {31'd0, branch_taken});
      chk("flush_ex", {31'd0, flush_ex}, {31'd0, branch_taken});
      chk("mc_busy", {31'd0, mc_busy}, {31'd0, busy});
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_stall_cnt", perf_stall_cnt, m_pstall);
      chk("perf_flush_cnt", perf_flush_cnt, m_pflush);
`endif
    end
    s_stall_if = stall_if; s_stall_id = stall_id; s_bubble = bubble_ex;
    s_flush_if = flush_if; s_flush_id = flush_id; s_flush_ex = flush_ex;
    s_busy = mc_busy;
    @(posedge clk);
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) ready_at[r] = 0;
      busy_until = 0;
      m_pstall = 0;
      m_pflush = 0;
    end else begin
      if (id_valid && id_mem_read && !e_stall && !branch_taken && id_rd_addr != 0)
        ready_at[id_rd_addr] = cyc + 1 + LOAD_LAT;
      if (!busy && ex_mc_start && !branch_taken && ex_mc_cycles != 0)
        busy_until = cyc + 1 + int'(ex_mc_cycles);
      if (e_stall) m_pstall++;
      if (branch_taken) m_pflush++;
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_mem_read = 0;
    ex_mc_start = 0; ex_mc_cycles = 0; branch_taken = 0;
  endtask

  task automatic set_id(input logic v, input int rs1, input logic u1, input int rs2,
                        input logic u2, input logic mr, input int rd);
    id_valid = v; id_rs1_addr = REG_AW'(rs1); id_rs1_used = u1;
    id_rs2_addr = REG_AW'(rs2); id_rs2_used = u2;
    id_mem_read = mr; id_rd_addr = REG_AW'(rd);
  endtask

  initial begin
    for (int r = 0; r < NUM_REGS; r++) ready_at[r] = 0;
    idle();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
    chk("rst_stall_if", {31'd0, s_stall_if}, 32'd0);
    chk("rst_bubble", {31'd0, s_bubble}, 32'd0);
    chk("rst_flush_ex", {31'd0, s_flush_ex}, 32'd0);
    chk("rst_mc_busy", {31'd0, s_busy}, 32'd0);

    // Load x5 then a dependent read: two stall/bubble cycles, then release.
    set_id(1, 0, 0, 0, 0, 1, 5); step();
    chk("lu_issue_nostall", {31'd0, s_stall_id}, 32'd0);
    set_id(1, 5, 1, 0, 0, 0, 10); step();
    chk("lu_c1_stall", {31'd0, s_stall_if}, 32'd1);
    chk("lu_c1_bubble", {31'd0, s_bubble}, 32'd1);
    step();
    chk("lu_c2_stall", {31'd0, s_stall_id}, 32'd1);
    chk("lu_c2_bubble", {31'd0, s_bubble}, 32'd1);
    step();
    chk("lu_release", {31'd0, s_stall_id}, 32'd0);

    // Load to x0 then read x0: never a stall.
    set_id(1, 0, 0, 0, 0, 1, 0); step();
    set_id(1, 0, 1, 0, 1, 0, 3); step();
    chk("x0_c1", {31'd0, s_stall_id}, 32'd0);
    step();
    chk("x0_c2", {31'd0, s_stall_id}, 32'd0);

    // Four-cycle multi-cycle op; a load-use during it stalls without bubbling.
    idle(); set_id(1, 0, 0, 0, 0, 1, 9); ex_mc_start = 1; ex_mc_cycles = 4; step();
    chk("mc_start_notbusy", {31'd0, s_busy}, 32'd0);
    idle(); set_id(1, 9, 1, 0, 0, 0, 11); step();
    chk("mc_haz_stall", {31'd0, s_stall_id}, 32'd1);
    chk("mc_haz_nobubble", {31'd0, s_bubble}, 32'd0);
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mc_busy_hold", {31'd0, s_busy}, 32'd1);
      chk("mc_nobubble", {31'd0, s_bubble}, 32'd0);
    end
    step();
    chk("mc_done", {31'd0, s_busy}, 32'd0);
    chk("mc_done_stall", {31'd0, s_stall_id}, 32'd0);

    // Load-use plus branch: flush wins, flushed load is not recorded.
    set_id(1, 0, 0, 0, 0, 1, 6); step();
    set_id(1, 6, 1, 0, 0, 1, 8); branch_taken = 1; step();
    chk("br_flush_if", {31'd0, s_flush_if}, 32'd1);
    chk("br_flush_id", {31'd0, s_flush_id}, 32'd1);
    chk("br_no_stall", {31'd0, s_stall_id}, 32'd0);
    chk("br_no_bubble", {31'd0, s_bubble}, 32'd0);
    branch_taken = 0; set_id(1, 8, 1, 0, 0, 0, 12); step();
    chk("flushed_load_absent", {31'd0, s_stall_id}, 32'd0);
    chk("flush_one_cycle", {31'd0, s_flush_ex}, 32'd0);

    // Older load survives a flush.
    set_id(1, 0, 0, 0, 0, 1, 13); step();
    idle(); branch_taken = 1; step();
    branch_taken = 0; set_id(1, 13, 1, 0, 0, 0, 14); step();
    chk("pending_survives_flush", {31'd0, s_stall_id}, 32'd1);
    idle(); step();

    // Branch coincident with mc start: no BUSY.
    ex_mc_start = 1; ex_mc_cycles = 3; branch_taken = 1; step();
    idle(); step();
    chk("br_cancels_mc", {31'd0, s_busy}, 32'd0);

    // Branch while BUSY: flush asserted, FSM keeps counting.
    ex_mc_start = 1; ex_mc_cycles = 3; step();
    idle(); step();
    branch_taken = 1; step();
    chk("busy_br_flush", {31'd0, s_flush_ex}, 32'd1);
    chk("busy_br_nostall", {31'd0, s_stall_id}, 32'd0);
    chk("busy_br_busy", {31'd0, s_busy}, 32'd1);
    branch_taken = 0; step();
    chk("busy_after_br", {31'd0, s_busy}, 32'd1);
    step();
    chk("busy_ended", {31'd0, s_busy}, 32'd0);

    // Reset during BUSY with x7 pending clears both.
    set_id(1, 0, 0, 0, 0, 1, 7); ex_mc_start = 1; ex_mc_cycles = 6; step();
    idle(); rst_n = 0; step();
    rst_n = 1; set_id(1, 7, 1, 0, 0, 0, 14); step();
    chk("rst_abort_busy", {31'd0, s_busy}, 32'd0);
    chk("rst_clear_x7", {31'd0, s_stall_id}, 32'd0);

    // Mixed traffic checked cycle by cycle against the model.
    for (int i = 0; i < 120; i++) begin
      rst_n = (i != 60);
      set_id(1'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), $urandom_range(0, 3));
      ex_mc_start  = ($urandom_range(0, 7) == 0);
      ex_mc_cycles = MC_CW'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 5) == 0);
      step();
    end
    rst_n = 1; idle();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
